// File: rtl/plic_claim_ctrl_pkg.sv
// Shared types and constants for the PLIC claim/complete engine.
// Holds the bus FSM state enum, holdoff/retry constants, default reg-bus structs and the address helper.
package plic_claim_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLAIM,
        ST_CMPL
    } bus_state_e;

    // Cycles a target waits after a claim before it may be claimed again.
    localparam logic [1:0] HoldoffCycles = 2'd3;
    localparam logic [1:0] RetryLimit    = 2'd3;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } plic_reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } plic_reg_rsp_t;

    function automatic logic [31:0] cc_addr(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input logic [31:0] idx);
        return base + stride * idx;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO, registered storage, no fall-through.
// Latency: push visible on data_o one cycle later; push while full is taken only alongside a pop.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [AW:0]           cnt_q;
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || pop_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/plic_claim_ctrl_rr.sv
// Round-robin picker: lowest requester at or after the pointer wins.
// Combinational grant; pointer moves past the winner when the grant is taken.
module plic_claim_ctrl_rr #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic            valid,
    output logic [IdxW-1:0] idx
);
    logic [IdxW-1:0] ptr_q;
    logic [IdxW:0]   cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (IdxW+1)'(i);
            if (cand >= (IdxW+1)'(N)) cand = cand - (IdxW+1)'(N);
            if (!valid && req[cand[IdxW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IdxW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      ptr_q <= '0;
        else if (advance) ptr_q <= (idx == IdxW'(N-1)) ? '0 : idx + 1'b1;
    end

endmodule

// File: rtl/plic_claim_ctrl.sv
// Claims PLIC IDs per target over the reg bus, queues them, and writes completions back.
// Latency: irq/completion to bus valid 1 cycle when idle; claim handshake to id_valid_o 1 cycle.
// Backpressure: reg_req_o held until ready; full queue blocks claims; full holding reg drops cpl_ready_o. Option: PLIC_CLAIM_CTRL_RETRY_EN.
module plic_claim_ctrl
    import plic_claim_ctrl_pkg::*;
#(
    parameter int unsigned NumTarget  = 2,
    parameter int unsigned SrcW       = 7,
    parameter int unsigned FifoDepth  = 4,
    parameter logic [31:0] CcBaseAddr = 32'h0,
    parameter logic [31:0] CcStride   = 32'h4,
    parameter type         reg_req_t  = plic_reg_req_t,
    parameter type         reg_rsp_t  = plic_reg_rsp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumTarget-1:0] irq_i,
    output reg_req_t             reg_req_o,
    input  reg_rsp_t             reg_rsp_i,
    output logic [NumTarget-1:0] id_valid_o,
    input  logic [NumTarget-1:0] id_ready_i,
    output logic [SrcW-1:0]      id_o [NumTarget],
    input  logic [NumTarget-1:0] cpl_valid_i,
    output logic [NumTarget-1:0] cpl_ready_o,
    input  logic [SrcW-1:0]      cpl_id_i [NumTarget]
);
    localparam int unsigned IdxW = (NumTarget > 1) ? $clog2(NumTarget) : 1;

    bus_state_e            state_q, state_d;
    reg_req_t              req_q;
    logic [IdxW-1:0]       cur_q;
    logic [1:0]            holdoff_q [NumTarget];
    logic [NumTarget-1:0]  cpl_full_q;
    logic [SrcW-1:0]       cpl_id_q [NumTarget];

    logic [NumTarget-1:0]  fifo_full, fifo_empty, push_id, pop_id;
    logic [NumTarget-1:0]  cpl_acc, cpl_req, claim_req;
    logic                  cpl_gnt_vld, clm_gnt_vld;
    logic [IdxW-1:0]       cpl_gnt_idx, clm_gnt_idx, sel_idx;
    logic [SrcW-1:0]       cpl_id_sel;
    logic                  issue_cpl, issue_claim, done, hs, retry;
    logic                  claim_done, cmpl_done;
    logic                  unused_rdata;

    assign hs           = req_q.valid && reg_rsp_i.ready;
    assign claim_done   = done && (state_q == ST_CLAIM);
    assign cmpl_done    = done && (state_q == ST_CMPL);
    assign unused_rdata = ^reg_rsp_i.rdata;

    // A completion offered this cycle is eligible immediately, bypassing the holding register.
    assign cpl_acc     = cpl_valid_i & ~cpl_full_q;
    assign cpl_req     = cpl_full_q | cpl_acc;
    assign cpl_ready_o = ~cpl_full_q;
    assign id_valid_o  = ~fifo_empty;
    assign sel_idx     = issue_cpl ? cpl_gnt_idx : clm_gnt_idx;
    assign cpl_id_sel  = cpl_full_q[cpl_gnt_idx] ? cpl_id_q[cpl_gnt_idx] : cpl_id_i[cpl_gnt_idx];

`ifdef PLIC_CLAIM_CTRL_RETRY_EN
    logic [1:0] retry_q;
    assign retry = reg_rsp_i.error && (retry_q != RetryLimit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)  retry_q <= '0;
        else if (hs)  retry_q <= retry ? retry_q + 2'd1 : 2'd0;
    end
`else
    assign retry = 1'b0;
`endif

    plic_claim_ctrl_rr #(.N(NumTarget)) i_rr_cpl (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req     (cpl_req),
        .advance (issue_cpl),
        .valid   (cpl_gnt_vld),
        .idx     (cpl_gnt_idx)
    );

    plic_claim_ctrl_rr #(.N(NumTarget)) i_rr_claim (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req     (claim_req),
        .advance (issue_claim),
        .valid   (clm_gnt_vld),
        .idx     (clm_gnt_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        issue_cpl   = 1'b0;
        issue_claim = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpl_gnt_vld) begin
                    issue_cpl = 1'b1;
                    state_d   = ST_CMPL;
                end else if (clm_gnt_vld) begin
                    issue_claim = 1'b1;
                    state_d     = ST_CLAIM;
                end
            end
            ST_CLAIM, ST_CMPL: begin
                if (hs && !retry) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A retry keeps the request asserted unchanged, so it reissues without re-arbitration.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q <= '0;
            cur_q <= '0;
        end else if (issue_cpl || issue_claim) begin
            req_q.valid <= 1'b1;
            req_q.write <= issue_cpl;
            req_q.addr  <= cc_addr(CcBaseAddr, CcStride, 32'(sel_idx));
            req_q.wdata <= issue_cpl ? 32'(cpl_id_sel) : 32'h0;
            req_q.wstrb <= '0;
            if (issue_cpl) req_q.wstrb <= '1;
            cur_q <= sel_idx;
        end else if (done) begin
            req_q.valid <= 1'b0;
        end
    end

    assign reg_req_o = req_q;

    for (genvar t = 0; t < NumTarget; t++) begin : g_tgt
        localparam logic [IdxW-1:0] T = IdxW'(t);

        assign claim_req[t] = irq_i[t] && !fifo_full[t] && (holdoff_q[t] == 2'd0);
        assign push_id[t]   = claim_done && (cur_q == T) && !reg_rsp_i.error &&
                              (reg_rsp_i.rdata[SrcW-1:0] != '0);
        assign pop_id[t]    = id_ready_i[t] && !fifo_empty[t];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                holdoff_q[t]  <= '0;
                cpl_full_q[t] <= 1'b0;
                cpl_id_q[t]   <= '0;
            end else begin
                if (claim_done && (cur_q == T)) holdoff_q[t] <= HoldoffCycles;
                else if (holdoff_q[t] != 2'd0)   holdoff_q[t] <= holdoff_q[t] - 2'd1;

                if (cmpl_done && (cur_q == T)) begin
                    cpl_full_q[t] <= 1'b0;
                end else if (cpl_acc[t]) begin
                    cpl_full_q[t] <= 1'b1;
                    cpl_id_q[t]   <= cpl_id_i[t];
                end
            end
        end

        fifo_v3 #(
            .DATA_WIDTH (SrcW),
            .DEPTH      (FifoDepth)
        ) i_id_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (1'b0),
            .full_o  (fifo_full[t]),
            .empty_o (fifo_empty[t]),
            .data_i  (reg_rsp_i.rdata[SrcW-1:0]),
            .push_i  (push_id[t]),
            .data_o  (id_o[t]),
            .pop_i   (pop_id[t])
        );
    end

endmodule

// File: doc/plic_claim_ctrl.md
# plic_claim_ctrl

Autonomous claim/complete engine that sits between the PLIC register port and the per-target interrupt consumers. It watches each target's `irq` line and claims the pending ID by reading that target's claim/complete register over the reg bus. Claimed IDs are queued per target for a core or accelerator to pop. Completions pushed by consumers are written back to the same register, so targets never touch the PLIC bus directly.

## Interface
- `NumTarget`, 2, number of PLIC targets served.
- `SrcW`, 7, interrupt ID width; matches PLIC source-ID width.
- `FifoDepth`, 4, per-target claimed-ID queue depth; power of two, ≥2.
- `CcBaseAddr`, 32'h0, bus address of target 0 claim/complete register.
- `CcStride`, 32'h4, address step between targets' claim/complete registers.
- `reg_req_t`, logic, register-bus request type.
- `reg_rsp_t`, logic, register-bus response type.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `irq_i` in NumTarget: PLIC target interrupt lines.
- `reg_req_o` out reg_req_t: bus request (valid/write/addr/wdata/wstrb).
- `reg_rsp_i` in reg_rsp_t: bus response (ready/rdata/error).
- `id_valid_o` out NumTarget: claimed ID available per target.
- `id_ready_i` in NumTarget: consumer pops ID.
- `id_o` out SrcW [NumTarget]: head claimed ID per target.
- `cpl_valid_i` in NumTarget: completion offered.
- `cpl_ready_o` out NumTarget: completion slot free.
- `cpl_id_i` in SrcW [NumTarget]: ID being completed.

## Operation
- Per target: one `FifoDepth` ID queue, one completion holding register, and a 2-bit holdoff counter.
- Bus FSM states:
  - IDLE: pick a request, drive it, go to CLAIM or CMPL.
  - CLAIM: hold the read until `valid&&ready`.
  - CMPL: hold the write until `valid&&ready`.
  - Both return to IDLE.
- Request eligibility:
  - Completion for t: holding register full.
  - Claim for t: `irq_i[t]`, queue not full, holdoff==0.
- Arbitration in IDLE:
  - Completions beat claims.
  - Round-robin within each class; pointer advances past the granted target.
- Claim access: read, `addr = CcBaseAddr + t*CcStride`.
  - `rdata[SrcW-1:0]` nonzero is pushed to queue t.
  - ID 0 (spurious) is discarded.
  - Holdoff[t] loads 3 on claim done and decrements to 0; this covers the PLIC's registered `ip`/`irq` update.
- Completion access: write, same address, `wdata = zero-extended ID`, `wstrb = '1`.
  - Holding register clears on bus handshake.
- Bus error (`error=1` on handshake):
  - Claim result is dropped.
  - Completion is dropped, and the holding register still clears.
  - Behaviour is modified by the Configuration macro.
- Simultaneous push and pop on a queue is legal in any occupancy, including full.
- `cpl_ready_o[t] = holding empty`; accept on `cpl_valid_i&&cpl_ready_o`.

## Timing
- Reset values:
  - FSM IDLE; `reg_req_o.valid=0`.
  - `id_valid_o=0`; `cpl_ready_o='1`.
  - Queues empty, holdoffs 0, RR pointers 0.
- `reg_req_o` is registered; it is stable while valid and ready is low.
- Latencies:
  - `irq_i` rise to bus valid: 1 cycle, if idle and uncontended.
  - Claim handshake to `id_valid_o`: 1 cycle.
  - Completion accept to bus valid: 1 cycle, if idle.
- Back-to-back: IDLE costs 1 cycle between transactions.
- Reset mid-transaction aborts the access; queued IDs are lost. Software must reinitialise the PLIC.

## Configuration
- `PLIC_CLAIM_CTRL_RETRY_EN` defined:
  - An errored access is reissued up to 3 times via a 2-bit retry counter.
  - Arbitration is not re-run between retries.
  - It is dropped after the 4th error.
- Undefined: an errored access is dropped immediately.

## Structure
- `plic_claim_ctrl_pkg`:
  - FSM state enum (IDLE/CLAIM/CMPL).
  - Holdoff constant (3).
  - Retry limit constant (3).
- Per-target queues use the existing `fifo_v3`; no new sub-module.
- One sub-module: `plic_claim_ctrl_rr`, a parameterised round-robin picker, instantiated once per class.

## Test plan
- Claim: `irq_i[0]=1`, bus returns rdata=5 with ready same cycle → read at CcBaseAddr; `id_valid_o[0]=1`, `id_o[0]=5` one cycle later.
- Spurious: claim returns 0 → nothing pushed; no further claim for 3 cycles even though irq stays high.
- Completion priority: `irq_i[1]=1` and `cpl_valid_i[0]` with ID 9 in the same cycle → write of 9 at CcBaseAddr first, then read at CcBaseAddr+4.
- Full queue: 4 claims on target 0 with no pops, `irq_i[0]` held → no 5th read. Pop once → 5th read issues.
- Stall and reset: `ready=0` for 10 cycles keeps req stable. `rst_ni` low mid-claim → req.valid=0, queues empty, `cpl_ready_o='1`.
- Error: rdata error on a claim → with `PLIC_CLAIM_CTRL_RETRY_EN` exactly 4 reads, else 1; no ID pushed.
